packet_pingpong_buf: RTL and testbench

PACKET_PINGPONG_BUF -- requirements
Module: packet_pingpong_buf

---
 rtl/packet_pingpong_buf.sv | 142 ++++++++++++++
 tb/tb_packet_pingpong_buf.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_pingpong_buf.sv
// Two-buffer packet store: the snooper fills one buffer while the forwarder drains the other.
// Buffers alternate through EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module packet_pingpong_buf #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  axi_aclk,
   input  logic                  axi_aresetn,
   input  logic [ADDR_WIDTH-1:0] snooper_wr_addr,
   input  logic [DATA_WIDTH-1:0] snooper_wr_data,
   input  logic                  snooper_wr_en,
   input  logic                  snooper_done,
   output logic                  ready_for_snooper,
   input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
   input  logic                  forwarder_rd_en,
   output logic [DATA_WIDTH-1:0] forwarder_rd_data,
   input  logic                  forwarder_done,
   output logic                  ready_for_forwarder,
   output logic [31:0]           len_to_forwarder,
   output logic [31:0]           dropped_count
);

   localparam int          DEPTH = 1 << ADDR_WIDTH;
   localparam logic [31:0] BYTES = 32'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      BUF_EMPTY    = 2'd0,
      BUF_FILLING  = 2'd1,
      BUF_FULL     = 2'd2,
      BUF_DRAINING = 2'd3
   } buf_state_e;

   buf_state_e            state_q [2];
   buf_state_e            state_d [2];
   logic                  wp_q, wp_d;
   logic                  rp_q, rp_d;
   logic [ADDR_WIDTH-1:0] max_addr_q, max_addr_d;
   logic [31:0]           len_q [2];
   logic [31:0]           len_d [2];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [31:0]           dropped_q, dropped_d;
   logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

   logic                  snp_ready;
   logic                  fwd_ready;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  snp_done_ok;
   logic                  fwd_done_ok;
   logic [ADDR_WIDTH-1:0] new_max;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [31:0]           new_len;

   assign snp_ready = (state_q[wp_q] == BUF_EMPTY) || (state_q[wp_q] == BUF_FILLING);
   assign fwd_ready = (state_q[rp_q] == BUF_FULL) || (state_q[rp_q] == BUF_DRAINING);

   assign wr_ok       = snooper_wr_en && snp_ready;
   assign rd_ok       = forwarder_rd_en && fwd_ready;
   // A done pulse closes the packet if it already holds data or a write lands in the same cycle.
   assign snp_done_ok = snooper_done && snp_ready &&
                        ((state_q[wp_q] == BUF_FILLING) || snooper_wr_en);
   assign fwd_done_ok = forwarder_done && fwd_ready;

   assign new_max  = (wr_ok && (snooper_wr_addr > max_addr_q)) ? snooper_wr_addr : max_addr_q;
   // One extra bit keeps a full buffer (max address all ones) from wrapping to zero words.
   assign word_cnt = {1'b0, new_max} + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign new_len  = 32'(word_cnt) * BYTES;

   always_comb begin
      state_d[0] = state_q[0];
      state_d[1] = state_q[1];
      len_d[0]   = len_q[0];
      len_d[1]   = len_q[1];
      wp_d       = wp_q;
      rp_d       = rp_q;
      max_addr_d = max_addr_q;
      dropped_d  = dropped_q;

      if (snp_done_ok) begin
         state_d[wp_q] = BUF_FULL;
         len_d[wp_q]   = new_len;
         wp_d          = ~wp_q;
         max_addr_d    = '0;
      end else if (wr_ok) begin
         state_d[wp_q] = BUF_FILLING;
         max_addr_d    = new_max;
      end

      if (snooper_done && !snp_ready && (dropped_q != 32'hFFFF_FFFF)) begin
         dropped_d = dropped_q + 32'd1;
      end

      // wp and rp never point at the same active buffer, so these updates cannot collide.
      if (rd_ok && (state_q[rp_q] == BUF_FULL)) begin
         state_d[rp_q] = BUF_DRAINING;
      end
      if (fwd_done_ok) begin
         state_d[rp_q] = BUF_EMPTY;
         rp_d          = ~rp_q;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q[0] <= BUF_EMPTY;
         state_q[1] <= BUF_EMPTY;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         max_addr_q <= '0;
         dropped_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         len_q[0]   <= len_d[0];
         len_q[1]   <= len_d[1];
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         max_addr_q <= max_addr_d;
         dropped_q  <= dropped_d;
         if (rd_ok) begin
            rd_data_q <= mem_q[rp_q][forwarder_rd_addr];
         end
      end
   end

   // Packet storage keeps its contents across reset.
   always_ff @(posedge axi_aclk) begin
      if (wr_ok) begin
         mem_q[wp_q][snooper_wr_addr] <= snooper_wr_data;
      end
   end

   assign ready_for_snooper   = snp_ready;
   assign ready_for_forwarder = fwd_ready;
   assign len_to_forwarder    = fwd_ready ? len_q[rp_q] : 32'd0;
   assign forwarder_rd_data   = rd_data_q;
   assign dropped_count       = dropped_q;

endmodule

// File: tb/tb_packet_pingpong_buf.sv
// Bench for packet_pingpong_buf: directed scenarios plus a randomized run against a packet-queue model.
module tb_packet_pingpong_buf;

   localparam int AW = 10;
   localparam int DW = 64;

   logic          axi_aclk;
   logic          axi_aresetn;
   logic [AW-1:0] snooper_wr_addr;
   logic [DW-1:0] snooper_wr_data;
   logic          snooper_wr_en;
   logic          snooper_done;
   logic          ready_for_snooper;
   logic [AW-1:0] forwarder_rd_addr;
   logic          forwarder_rd_en;
   logic [DW-1:0] forwarder_rd_data;
   logic          forwarder_done;
   logic          ready_for_forwarder;
   logic [31:0]   len_to_forwarder;
   logic [31:0]   dropped_count;

   int checks = 0;
   int errors = 0;

   packet_pingpong_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .axi_aclk            (axi_aclk),
      .axi_aresetn         (axi_aresetn),
      .snooper_wr_addr     (snooper_wr_addr),
      .snooper_wr_data     (snooper_wr_data),
      .snooper_wr_en       (snooper_wr_en),
      .snooper_done        (snooper_done),
      .ready_for_snooper   (ready_for_snooper),
      .forwarder_rd_addr   (forwarder_rd_addr),
      .forwarder_rd_en     (forwarder_rd_en),
      .forwarder_rd_data   (forwarder_rd_data),
      .forwarder_done      (forwarder_done),
      .ready_for_forwarder (ready_for_forwarder),
      .len_to_forwarder    (len_to_forwarder),
      .dropped_count       (dropped_count)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   // Inputs set before step() are sampled at the next rising edge; outputs are read 1 ns after it.
   task automatic step();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic idle_inputs();
      snooper_wr_addr   = '0;
      snooper_wr_data   = '0;
      snooper_wr_en     = 1'b0;
      snooper_done      = 1'b0;
      forwarder_rd_addr = '0;
      forwarder_rd_en   = 1'b0;
      forwarder_done    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      axi_aresetn = 1'b0;
      repeat (2) step();
      axi_aresetn = 1'b1;
      step();
   endtask

   task automatic snp_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic with_done);
      snooper_wr_addr = a;
      snooper_wr_data = d;
      snooper_wr_en   = 1'b1;
      snooper_done    = with_done;
      step();
      snooper_wr_en   = 1'b0;
      snooper_done    = 1'b0;
   endtask

   task automatic snp_done_pulse();
      snooper_done = 1'b1;
      step();
      snooper_done = 1'b0;
   endtask

   task automatic fwd_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      forwarder_rd_addr = a;
      forwarder_rd_en   = 1'b1;
      step();
      forwarder_rd_en   = 1'b0;
      d = forwarder_rd_data;
   endtask

   task automatic fwd_done_pulse();
      forwarder_done = 1'b1;
      step();
      forwarder_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ready_for_snooper !== 1'b1) begin
         errors++; $display("FAIL reset_rdy_snp got %0b exp 1", ready_for_snooper);
      end
      checks++;
      if (ready_for_forwarder !== 1'b0) begin
         errors++; $display("FAIL reset_rdy_fwd got %0b exp 0", ready_for_forwarder);
      end
      checks++;
      if (len_to_forwarder !== 32'd0) begin
         errors++; $display("FAIL reset_len got %0d exp 0", len_to_forwarder);
      end
      checks++;
      if (dropped_count !== 32'd0) begin
         errors++; $display("FAIL reset_dropped got %0d exp 0", dropped_count);
      end
      checks++;
      if (forwarder_rd_data !== '0) begin
         errors++; $display("FAIL reset_rd_data got %h exp 0", forwarder_rd_data);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] d;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 4; i++) snp_write(AW'(i), DW'(8'h11 * (i + 1)), 1'b0);
      snp_done_pulse();
      checks++;
      if (ready_for_forwarder !== 1'b1) begin
         errors++; $display("FAIL basic_rdy_fwd got %0b exp 1", ready_for_forwarder);
      end
      checks++;
      if (len_to_forwarder !== 32'd32) begin
         errors++; $display("FAIL basic_len got %0d exp 32", len_to_forwarder);
      end
      for (int i = 0; i < 4; i++) begin
         fwd_read(AW'(i), d);
         exp_d = DW'(8'h11 * (i + 1));
         checks++;
         if (d !== exp_d) begin
            errors++; $display("FAIL basic_rd%0d got %h exp %h", i, d, exp_d);
         end
      end
      forwarder_rd_addr = AW'(1);
      step();
      checks++;
      if (forwarder_rd_data !== 64'h44) begin
         errors++; $display("FAIL basic_rd_hold got %h exp 44", forwarder_rd_data);
      end
      fwd_done_pulse();
      checks++;
      if (ready_for_forwarder !== 1'b0) begin
         errors++; $display("FAIL basic_fwd_released got %0b exp 0", ready_for_forwarder);
      end
   endtask

   task automatic test_both_full();
      logic [DW-1:0] d;
      snp_write(AW'(0), 64'hA0, 1'b0);
      snp_write(AW'(1), 64'hA1, 1'b1);
      snp_write(AW'(0), 64'hB0, 1'b1);
      checks++;
      if (ready_for_snooper !== 1'b0) begin
         errors++; $display("FAIL both_rdy_snp got %0b exp 0", ready_for_snooper);
      end
      snp_done_pulse();
      checks++;
      if (dropped_count !== 32'd1) begin
         errors++; $display("FAIL both_dropped got %0d exp 1", dropped_count);
      end
      snp_write(AW'(0), 64'hDEAD, 1'b0);
      checks++;
      if (len_to_forwarder !== 32'd16) begin
         errors++; $display("FAIL both_len_a got %0d exp 16", len_to_forwarder);
      end
      fwd_read(AW'(0), d);
      checks++;
      if (d !== 64'hA0) begin
         errors++; $display("FAIL both_ignored_wr got %h exp a0", d);
      end
      fwd_read(AW'(1), d);
      checks++;
      if (d !== 64'hA1) begin
         errors++; $display("FAIL both_rd_a1 got %h exp a1", d);
      end
      checks++;
      if (ready_for_snooper !== 1'b0) begin
         errors++; $display("FAIL both_rdy_snp_hold got %0b exp 0", ready_for_snooper);
      end
      fwd_done_pulse();
      checks++;
      if (ready_for_snooper !== 1'b1) begin
         errors++; $display("FAIL both_rdy_snp_rise got %0b exp 1", ready_for_snooper);
      end
      checks++;
      if (len_to_forwarder !== 32'd8) begin
         errors++; $display("FAIL both_len_b got %0d exp 8", len_to_forwarder);
      end
      fwd_read(AW'(0), d);
      checks++;
      if (d !== 64'hB0) begin
         errors++; $display("FAIL both_rd_b0 got %h exp b0", d);
      end
      fwd_done_pulse();
   endtask

   task automatic test_max_addr();
      logic [DW-1:0] d;
      snp_write(AW'(1023), 64'h1234_5678_9ABC_DEF0, 1'b0);
      snp_done_pulse();
      checks++;
      if (len_to_forwarder !== 32'd8192) begin
         errors++; $display("FAIL max_len got %0d exp 8192", len_to_forwarder);
      end
      fwd_read(AW'(1023), d);
      checks++;
      if (d !== 64'h1234_5678_9ABC_DEF0) begin
         errors++; $display("FAIL max_rd got %h exp 123456789abcdef0", d);
      end
      fwd_done_pulse();
   endtask

   task automatic test_empty_done();
      logic [DW-1:0] d;
      snp_done_pulse();
      checks++;
      if (ready_for_forwarder !== 1'b0) begin
         errors++; $display("FAIL empty_rdy_fwd got %0b exp 0", ready_for_forwarder);
      end
      checks++;
      if (ready_for_snooper !== 1'b1) begin
         errors++; $display("FAIL empty_rdy_snp got %0b exp 1", ready_for_snooper);
      end
      snp_write(AW'(0), 64'hC0, 1'b0);
      snp_write(AW'(1), 64'hC1, 1'b0);
      snp_write(AW'(2), 64'hC2, 1'b1);
      checks++;
      if (ready_for_forwarder !== 1'b1) begin
         errors++; $display("FAIL empty_wp_kept got %0b exp 1", ready_for_forwarder);
      end
      checks++;
      if (len_to_forwarder !== 32'd24) begin
         errors++; $display("FAIL empty_same_cycle_len got %0d exp 24", len_to_forwarder);
      end
      fwd_read(AW'(2), d);
      checks++;
      if (d !== 64'hC2) begin
         errors++; $display("FAIL empty_rd_c2 got %h exp c2", d);
      end
      fwd_done_pulse();
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (ready_for_snooper !== 1'b1 || ready_for_forwarder !== 1'b0 || len_to_forwarder !== 32'd0 ||
          dropped_count !== 32'd0 || forwarder_rd_data !== '0) begin
         errors++;
         $display("FAIL %s got rs=%0b rf=%0b len=%0d drop=%0d rd=%h exp rs=1 rf=0 len=0 drop=0 rd=0",
                  tag, ready_for_snooper, ready_for_forwarder, len_to_forwarder, dropped_count,
                  forwarder_rd_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      snp_write(AW'(0), 64'hE0, 1'b0);
      axi_aresetn = 1'b0;
      #1;
      check_reset_outputs("rst_mid_fill");
      step();
      axi_aresetn = 1'b1;
      step();
      snp_write(AW'(3), 64'hE3, 1'b1);
      fwd_read(AW'(3), d);
      checks++;
      if (d !== 64'hE3) begin
         errors++; $display("FAIL rst_pre_drain_rd got %h exp e3", d);
      end
      axi_aresetn = 1'b0;
      #1;
      check_reset_outputs("rst_mid_drain");
      step();
      axi_aresetn = 1'b1;
      step();
      snp_write(AW'(0), 64'hF0, 1'b1);
      checks++;
      if (len_to_forwarder !== 32'd8 || ready_for_forwarder !== 1'b1) begin
         errors++; $display("FAIL rst_after_len got len=%0d rf=%0b exp len=8 rf=1",
                            len_to_forwarder, ready_for_forwarder);
      end
      fwd_done_pulse();
   endtask

   // Model: complete packets form a queue (front is being forwarded); at most two may be held.
   task automatic test_random();
      int            exp_q[$];
      int            pkt_len_m [int];
      logic [DW-1:0] mem_m [int];
      int            cur_id;
      bit            cur_has;
      int            cur_max;
      int            drop_m;
      logic [DW-1:0] exp_rd;
      bit            rd_known;
      bit            m_snp_rdy, m_fwd_rdy;
      int            key;
      int            exp_len;

      do_reset();
      cur_id = 0; cur_has = 0; cur_max = 0; drop_m = 0; exp_rd = '0; rd_known = 1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         idle_inputs();
         snooper_wr_en   = ($urandom_range(0, 99) < 60);
         snooper_wr_addr = AW'($urandom_range(0, 7));
         snooper_wr_data = {$urandom, $urandom};
         snooper_done    = ($urandom_range(0, 99) < 15);
         forwarder_rd_en = ($urandom_range(0, 99) < 50);
         forwarder_done  = ($urandom_range(0, 99) < 12);
         m_snp_rdy = (exp_q.size() < 2);
         m_fwd_rdy = (exp_q.size() > 0);
         if (m_fwd_rdy) forwarder_rd_addr = AW'($urandom_range(0, pkt_len_m[exp_q[0]] / 8 - 1));

         if (m_fwd_rdy && forwarder_rd_en) begin
            key = exp_q[0] * 1024 + int'(forwarder_rd_addr);
            if (mem_m.exists(key)) begin
               exp_rd = mem_m[key]; rd_known = 1;
            end else begin
               rd_known = 0;
            end
         end
         if (m_fwd_rdy && forwarder_done) void'(exp_q.pop_front());
         if (m_snp_rdy && snooper_wr_en) begin
            mem_m[cur_id * 1024 + int'(snooper_wr_addr)] = snooper_wr_data;
            cur_has = 1;
            if (int'(snooper_wr_addr) > cur_max) cur_max = int'(snooper_wr_addr);
         end
         if (snooper_done) begin
            if (!m_snp_rdy) begin
               drop_m++;
            end else if (cur_has) begin
               pkt_len_m[cur_id] = (cur_max + 1) * (DW / 8);
               exp_q.push_back(cur_id);
               cur_id++; cur_has = 0; cur_max = 0;
            end
         end
         step();

         exp_len = (exp_q.size() > 0) ? pkt_len_m[exp_q[0]] : 0;
         checks++;
         if (ready_for_snooper !== (exp_q.size() < 2) || ready_for_forwarder !== (exp_q.size() > 0)) begin
            errors++; $display("FAIL rand_ready cyc %0d got rs=%0b rf=%0b exp rs=%0b rf=%0b", cyc,
                               ready_for_snooper, ready_for_forwarder, exp_q.size() < 2, exp_q.size() > 0);
         end
         checks++;
         if (len_to_forwarder !== 32'(exp_len)) begin
            errors++; $display("FAIL rand_len cyc %0d got %0d exp %0d", cyc, len_to_forwarder, exp_len);
         end
         checks++;
         if (dropped_count !== 32'(drop_m)) begin
            errors++; $display("FAIL rand_dropped cyc %0d got %0d exp %0d", cyc, dropped_count, drop_m);
         end
         if (rd_known) begin
            checks++;
            if (forwarder_rd_data !== exp_rd) begin
               errors++; $display("FAIL rand_rd_data cyc %0d got %h exp %h", cyc, forwarder_rd_data, exp_rd);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      axi_aresetn = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_both_full();
      test_max_addr();
      test_empty_done();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
